mole_sched: RTL and testbench
=============================

# mole_sched

Round scheduler for the whack-a-mole game, sitting directly downstream of the 16-bit PRBS generator. It consumes the generator's pseudo-random word to choose which mole lights and for how long, and pulses the generator's shift enable once per round. It times each round, detects hits from the debounced player buttons, and keeps score and miss counts until the game ends.

## Interface
- NUM_MOLES, 8: number of moles. Fixed power of two; IDX_W = log2(NUM_MOLES).
- TICK_DIV, 50000: clk cycles per game tick, ≥2.
- LIT_BASE, 4: minimum lit time in ticks.
- GAP_TICKS, 2: dark time between rounds in ticks, ≥1.
- MAX_MISSES, 5: miss count that ends the game.
- NUM_ROUNDS, 30: rounds per game.

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a game.
- rand_seq  in  16  random word from the PRBS generator.
- rand_shift  out  1  shift enable to the PRBS generator; one-cycle pulse.
- hit_btn  in  NUM_MOLES  debounced, synchronous, level-high buttons.
- mole_on  out  NUM_MOLES  one-hot lit mole, or all zero.
- score  out  8  hits this game; saturates at 255.
- misses  out  8  misses this game.
- busy  out  1  high in PICK/SHOW/GAP.
- game_over  out  1  high in DONE.

## Operation
- Reset (rst=0, async): state IDLE; mole_on=0, score=0, misses=0, rand_shift=0, busy=0, game_over=0. Internal prev_idx=0, round count=0, tick counter=0, button history=0.
- Button edges: btn_rise = hit_btn & ~hit_btn_q, where hit_btn_q is registered every cycle in all states.
- IDLE: on start, clear score, misses and round count, then go to PICK. All other inputs are ignored.
- PICK (1 cycle):
  - idx = rand_seq[IDX_W-1:0]. If idx == prev_idx, idx = (idx+1) mod NUM_MOLES.
  - lit = LIT_BASE + rand_seq[7:4] ticks.
  - Store idx as prev_idx; increment the round count.
  - Assert rand_shift for this cycle only.
  - Next state: SHOW.
- SHOW:
  - mole_on = 1 << idx; the tick counter starts at 0.
  - Correct hit, btn_rise[idx]=1: score++ (saturating), go to GAP. This holds even if other bits rise in the same cycle.
  - Wrong press only, btn_rise≠0 and btn_rise[idx]=0: misses++, stay in SHOW, timer continues.
  - Timeout after lit ticks: misses++, go to GAP.
  - A correct hit in the timeout cycle counts as a hit; no miss is recorded.
- GAP:
  - mole_on=0. Button presses are ignored, but history still updates.
  - After GAP_TICKS ticks: if misses ≥ MAX_MISSES or round count == NUM_ROUNDS, go to DONE; otherwise go to PICK.
  - The misses check takes precedence. Every SHOW exit passes through a full GAP before DONE.
- DONE: game_over=1, mole_on=0, score and misses held. A start pulse clears the counts and goes to PICK. DONE is exited only by start or reset.
- start is ignored while busy.
- Reset asserted mid-game returns everything to reset values immediately; the game does not resume.

## Timing
- Tick counter:
  - Counts clk cycles 0..TICK_DIV-1 and is cleared on entry to SHOW and GAP.
  - One tick = TICK_DIV cycles.
  - SHOW lasts exactly lit×TICK_DIV cycles, and GAP exactly GAP_TICKS×TICK_DIV cycles, when no hit occurs.
- Latencies:
  - start → PICK: 1 cycle. PICK → mole_on visible: 1 cycle.
  - btn_rise → mole_on cleared and score updated: next clock edge.
- rand_seq is sampled in the PICK cycle. The generator's registered output settles 2 cycles after rand_shift, well before the next PICK. No other cycle reads rand_seq.
- All outputs are registered.

## Test plan
- Basic round: TICK_DIV=4. Reset, pulse start, rand_seq=16'h0035 at PICK → rand_shift is high for 1 cycle; mole_on=8'b0010_0000 for 28 cycles (lit=7); then misses=1 and mole_on=0 for 8 cycles.
- Hit: as above, raise hit_btn[5] 10 cycles into SHOW → mole_on=0 on the next edge, score=1, misses=0, and the next PICK follows 8 cycles later.
- Repeat avoidance and wrong press: prev_idx=5 and rand_seq=16'h0005 → mole_on=8'b0100_0000. Pressing hit_btn[2] → misses+1, mole stays lit. Holding hit_btn[6] high from before SHOW gives no hit until it is released and pressed again.
- Simultaneous: hit_btn[idx] rises in the final cycle of SHOW together with a wrong button → score+1, misses unchanged.
- Game end: 5 timeouts → game_over=1 after the 5th GAP with misses=5. start in DONE → score=0, misses=0, busy=1. start while busy has no effect.
- Async reset: drop rst during SHOW, asynchronously to clk → mole_on, score, misses, busy and rand_shift all read 0 before the next edge. After release, IDLE holds until start.

Source files
------------

// File: rtl/mole_sched_if.sv
// Signals between the round scheduler and the PRBS generator, the player buttons and the display.
// The slave modport is the scheduler's side of the link.
interface mole_sched_if #(
  parameter int unsigned NUM_MOLES = 8
);
  logic                 start;
  logic [15:0]          rand_seq;
  logic                 rand_shift;
  logic [NUM_MOLES-1:0] hit_btn;
  logic [NUM_MOLES-1:0] mole_on;
  logic [7:0]           score;
  logic [7:0]           misses;
  logic                 busy;
  logic                 game_over;

  modport master (
    output start, rand_seq, hit_btn,
    input  rand_shift, mole_on, score, misses, busy, game_over
  );

  modport slave (
    input  start, rand_seq, hit_btn,
    output rand_shift, mole_on, score, misses, busy, game_over
  );
endinterface

// File: rtl/mole_sched.sv
// Whack-a-mole round scheduler: picks a mole and lit time from the PRBS word, times each round
// in game ticks, scores rising-edge hits and ends the game on too many misses or rounds.
module mole_sched #(
  parameter int unsigned NUM_MOLES  = 8,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned LIT_BASE   = 4,
  parameter int unsigned GAP_TICKS  = 2,
  parameter int unsigned MAX_MISSES = 5,
  parameter int unsigned NUM_ROUNDS = 30
) (
  input  logic         clk,
  input  logic         rst,
  mole_sched_if.slave  bus
);
  localparam int unsigned IDX_W     = $clog2(NUM_MOLES);
  localparam int unsigned CNT_W     = $clog2(TICK_DIV);
  localparam int unsigned MAX_TICKS = (LIT_BASE + 15 > GAP_TICKS) ? LIT_BASE + 15 : GAP_TICKS;
  localparam int unsigned TNUM_W    = $clog2(MAX_TICKS + 1);
  localparam int unsigned RND_W     = $clog2(NUM_ROUNDS + 1);

  typedef enum logic [2:0] {StIdle, StPick, StShow, StGap, StDone} state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;       // current mole, doubles as prev_idx for the next pick
  logic [TNUM_W-1:0]    tick_lim_q;  // last tick index of the current SHOW or GAP
  logic [TNUM_W-1:0]    tick_num_q;
  logic [CNT_W-1:0]     tick_cnt_q;
  logic [RND_W-1:0]     round_q;
  logic [NUM_MOLES-1:0] btn_q;
  logic [NUM_MOLES-1:0] mole_on_q;
  logic [7:0]           score_q;
  logic [7:0]           misses_q;
  logic                 rand_shift_q;
  logic                 busy_q;
  logic                 game_over_q;

  logic [NUM_MOLES-1:0] btn_rise;
  logic [IDX_W-1:0]     pick_idx;
  logic                 tick_end;
  logic                 tick_last;
  logic                 unused_rand;

  assign btn_rise    = bus.hit_btn & ~btn_q;
  assign tick_end    = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
  assign tick_last   = tick_end && (tick_num_q == tick_lim_q);
  assign unused_rand = ^bus.rand_seq[15:8];

  always_comb begin
    pick_idx = bus.rand_seq[IDX_W-1:0];
    if (pick_idx == idx_q) begin
      pick_idx = pick_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      tick_lim_q   <= '0;
      tick_num_q   <= '0;
      tick_cnt_q   <= '0;
      round_q      <= '0;
      btn_q        <= '0;
      mole_on_q    <= '0;
      score_q      <= '0;
      misses_q     <= '0;
      rand_shift_q <= 1'b0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      btn_q        <= bus.hit_btn;
      rand_shift_q <= 1'b0;
      if (state_q == StShow || state_q == StGap) begin
        if (tick_end) begin
          tick_cnt_q <= '0;
          tick_num_q <= tick_num_q + TNUM_W'(1);
        end else begin
          tick_cnt_q <= tick_cnt_q + CNT_W'(1);
        end
      end

      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q      <= StPick;
            score_q      <= '0;
            misses_q     <= '0;
            round_q      <= '0;
            rand_shift_q <= 1'b1;
            busy_q       <= 1'b1;
            game_over_q  <= 1'b0;
          end
        end
        StPick: begin
          state_q    <= StShow;
          idx_q      <= pick_idx;
          mole_on_q  <= NUM_MOLES'(1) << pick_idx;
          tick_lim_q <= TNUM_W'(LIT_BASE - 1) + TNUM_W'(bus.rand_seq[7:4]);
          tick_num_q <= '0;
          tick_cnt_q <= '0;
          round_q    <= round_q + RND_W'(1);
        end
        StShow: begin
          if (btn_rise[idx_q] || tick_last) begin
            state_q    <= StGap;
            mole_on_q  <= '0;
            tick_lim_q <= TNUM_W'(GAP_TICKS - 1);
            tick_num_q <= '0;
            tick_cnt_q <= '0;
            // A correct hit wins over a timeout landing in the same cycle.
            if (btn_rise[idx_q]) begin
              if (score_q != 8'hFF) score_q <= score_q + 8'd1;
            end else if (misses_q != 8'hFF) begin
              misses_q <= misses_q + 8'd1;
            end
          end else if (|btn_rise) begin
            if (misses_q != 8'hFF) misses_q <= misses_q + 8'd1;
          end
        end
        StGap: begin
          if (tick_last) begin
            if (misses_q >= 8'(MAX_MISSES) || round_q == RND_W'(NUM_ROUNDS)) begin
              state_q     <= StDone;
              busy_q      <= 1'b0;
              game_over_q <= 1'b1;
            end else begin
              state_q      <= StPick;
              rand_shift_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rand_shift = rand_shift_q;
  assign bus.mole_on    = mole_on_q;
  assign bus.score      = score_q;
  assign bus.misses     = misses_q;
  assign bus.busy       = busy_q;
  assign bus.game_over  = game_over_q;
endmodule

// File: tb/tb_mole_sched.sv
// Directed bench for mole_sched with TICK_DIV=4: timeouts, hits, repeat avoidance, wrong and
// held presses, game end by misses and by round count, start while busy, async reset.
module tb_mole_sched;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [2:0] prev;
  logic [2:0] idx;
  logic [7:0] m;

  mole_sched_if #(.NUM_MOLES(8)) bus ();

  mole_sched #(
    .NUM_MOLES (8),
    .TICK_DIV  (4),
    .LIT_BASE  (4),
    .GAP_TICKS (2),
    .MAX_MISSES(5),
    .NUM_ROUNDS(30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] mole, input logic [7:0] sc,
                         input logic [7:0] mi, input logic bsy, input logic go,
                         input logic sh);
    chk({tag, "_mole"}, 32'(bus.mole_on), 32'(mole));
    chk({tag, "_score"}, 32'(bus.score), 32'(sc));
    chk({tag, "_misses"}, 32'(bus.misses), 32'(mi));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(bsy));
    chk({tag, "_over"}, 32'(bus.game_over), 32'(go));
    chk({tag, "_shift"}, 32'(bus.rand_shift), 32'(sh));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered in PICK with rand_seq already set (lit=4); returns one edge after GAP ends.
  task automatic timeout_round(input string tag, input logic [7:0] mole,
                               input logic [7:0] exp_miss);
    chk({tag, "_pick"}, 32'(bus.rand_shift), 32'd1);
    step(1);
    chk({tag, "_lit"}, 32'(bus.mole_on), 32'(mole));
    step(15);
    chk({tag, "_last"}, 32'(bus.mole_on), 32'(mole));
    step(1);
    chk({tag, "_dark"}, 32'(bus.mole_on), 32'd0);
    chk({tag, "_miss"}, 32'(bus.misses), 32'(exp_miss));
    step(7);
    chk({tag, "_gapbusy"}, 32'(bus.busy), 32'd1);
    step(1);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.rand_seq = 16'h0000;
    bus.hit_btn  = 8'h00;
    rst          = 1'b0;
    #22;
    chk_out("reset", 8'h00, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(3);
    chk_out("idle", 8'h00, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Round 1: 0x35 -> mole 5, lit 7 ticks = 28 cycles, timeout.
    bus.rand_seq = 16'h0035;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk_out("pick1", 8'h00, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    step(1);
    chk_out("show1", 8'h20, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    step(27);
    chk("show1_last", 32'(bus.mole_on), 32'h20);
    step(1);
    chk_out("gap1", 8'h00, 8'd0, 8'd1, 1'b1, 1'b0, 1'b0);
    bus.hit_btn = 8'h40;
    step(7);
    chk("gap1_end_shift", 32'(bus.rand_shift), 32'd0);

    // Round 2: 0x05 repeats mole 5 -> mole 6; button 6 held since GAP.
    bus.rand_seq = 16'h0005;
    step(1);
    chk_out("pick2", 8'h00, 8'd0, 8'd1, 1'b1, 1'b0, 1'b1);
    step(1);
    chk_out("show2", 8'h40, 8'd0, 8'd1, 1'b1, 1'b0, 1'b0);
    step(2);
    chk("held_no_hit", 32'(bus.score), 32'd0);
    bus.hit_btn = 8'h44;
    step(1);
    chk_out("wrong", 8'h40, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0);
    bus.hit_btn = 8'h40;
    step(1);
    bus.hit_btn = 8'h00;
    step(1);
    bus.hit_btn = 8'h40;
    step(1);
    chk_out("rehit", 8'h00, 8'd1, 8'd2, 1'b1, 1'b0, 1'b0);
    bus.hit_btn = 8'h00;
    step(7);
    chk("gap2_end_shift", 32'(bus.rand_shift), 32'd0);

    // Round 3: 0x33 -> mole 3, hit 10 cycles into SHOW.
    bus.rand_seq = 16'h0033;
    step(1);
    chk("pick3", 32'(bus.rand_shift), 32'd1);
    step(1);
    chk("show3", 32'(bus.mole_on), 32'h08);
    step(10);
    bus.hit_btn = 8'h08;
    step(1);
    chk_out("hit3", 8'h00, 8'd2, 8'd2, 1'b1, 1'b0, 1'b0);
    bus.hit_btn = 8'h00;
    step(7);
    chk("gap3_end_shift", 32'(bus.rand_shift), 32'd0);

    // Round 4: 0x01 -> mole 1, correct + wrong press in the final SHOW cycle.
    bus.rand_seq = 16'h0001;
    step(1);
    chk("pick4", 32'(bus.rand_shift), 32'd1);
    step(1);
    chk("show4", 32'(bus.mole_on), 32'h02);
    step(15);
    chk("show4_last", 32'(bus.mole_on), 32'h02);
    bus.hit_btn = 8'h82;
    step(1);
    chk_out("simul", 8'h00, 8'd3, 8'd2, 1'b1, 1'b0, 1'b0);
    bus.hit_btn = 8'h00;
    step(8);

    // Three timeouts take misses to 5 and end the game.
    bus.rand_seq = 16'h0002;
    timeout_round("to5", 8'h04, 8'd3);
    bus.rand_seq = 16'h0002;
    timeout_round("to6", 8'h08, 8'd4);
    bus.rand_seq = 16'h0007;
    timeout_round("to7", 8'h80, 8'd5);
    chk_out("done1", 8'h00, 8'd3, 8'd5, 1'b0, 1'b1, 1'b0);
    step(4);
    bus.hit_btn = 8'hFF;
    step(2);
    chk_out("done1_hold", 8'h00, 8'd3, 8'd5, 1'b0, 1'b1, 1'b0);
    bus.hit_btn = 8'h00;

    // Restart from DONE; start during SHOW is ignored; five timeouts end it.
    bus.rand_seq = 16'h0000;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk_out("restart", 8'h00, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    step(1);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk_out("start_busy", 8'h01, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    step(14);
    chk("g2r1_last", 32'(bus.mole_on), 32'h01);
    step(1);
    chk("g2r1_miss", 32'(bus.misses), 32'd1);
    step(8);
    bus.rand_seq = 16'h0000;
    timeout_round("g2r2", 8'h02, 8'd2);
    bus.rand_seq = 16'h0004;
    timeout_round("g2r3", 8'h10, 8'd3);
    bus.rand_seq = 16'h0004;
    timeout_round("g2r4", 8'h20, 8'd4);
    bus.rand_seq = 16'h0006;
    timeout_round("g2r5", 8'h40, 8'd5);
    chk_out("done2", 8'h00, 8'd0, 8'd5, 1'b0, 1'b1, 1'b0);

    // 30 immediate hits end the game on round count.
    prev = 3'd6;
    bus.rand_seq = 16'd5;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      idx = bus.rand_seq[2:0];
      if (idx == prev) idx = idx + 3'd1;
      prev = idx;
      m = 8'd1 << idx;
      chk("r30_pick", 32'(bus.rand_shift), 32'd1);
      step(1);
      chk("r30_mole", 32'(bus.mole_on), 32'(m));
      bus.hit_btn = m;
      step(1);
      bus.hit_btn = 8'h00;
      chk("r30_score", 32'(bus.score), 32'(i + 1));
      bus.rand_seq = 16'((i + 2) * 37 + 5);
      step(8);
    end
    chk_out("done30", 8'h00, 8'd30, 8'd0, 1'b0, 1'b1, 1'b0);

    // Async reset in the middle of a SHOW with nonzero score and misses.
    bus.rand_seq = 16'h0002;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    idx = 3'd2;
    if (idx == prev) idx = idx + 3'd1;
    prev = idx;
    step(1);
    bus.hit_btn = 8'd1 << idx;
    step(1);
    bus.hit_btn = 8'h00;
    step(8);
    bus.rand_seq = 16'h0003;
    idx = 3'd3;
    if (idx == prev) idx = idx + 3'd1;
    step(1);
    bus.hit_btn = 8'd1 << (idx + 3'd1);
    step(1);
    bus.hit_btn = 8'h00;
    chk_out("pre_rst", 8'd1 << idx, 8'd1, 8'd1, 1'b1, 1'b0, 1'b0);
    step(2);
    #3 rst = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    step(5);
    chk_out("post_rst", 8'h00, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk_out("post_rst_start", 8'h00, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
